pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 115 +++++++++++
 tb/tb_pc_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch sequencer with a writable branch-target LUT.
// Optional define RELATIVE_BRANCH_EN: LUT entries are PC-relative offsets instead of absolute targets.
module pc_fetch_unit #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned LUT_DEPTH = 16,
    localparam int unsigned IDX_W    = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             TakeBranch,
    input  logic             Halt,
    input  logic [IDX_W-1:0] LutIdx,
    input  logic             LutWrEn,
    input  logic [PC_W-1:0]  LutWrData,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             InstValid,
    output logic             Done,
    output logic             BranchTaken
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            valid_nxt;
    logic            done_nxt;
    logic            taken_nxt;
    logic [PC_W-1:0] branch_target;
    logic            lut_wr;

    logic [PC_W-1:0] lut [LUT_DEPTH];

`ifdef RELATIVE_BRANCH_EN
    assign branch_target = ProgCtr + lut[LutIdx];
`else
    assign branch_target = lut[LutIdx];
`endif

    // The table is frozen while a program runs so targets cannot shift under it.
    assign lut_wr = LutWrEn && (state != ST_RUN);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            lut <= '{default: '0};
        end else if (lut_wr) begin
            lut[LutIdx] <= LutWrData;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= ST_IDLE;
            ProgCtr     <= '0;
            InstValid   <= 1'b0;
            Done        <= 1'b0;
            BranchTaken <= 1'b0;
        end else begin
            state       <= state_nxt;
            ProgCtr     <= pc_nxt;
            InstValid   <= valid_nxt;
            Done        <= done_nxt;
            BranchTaken <= taken_nxt;
        end
    end

    // Next-state / next-output: Stall > Halt > taken branch > increment while running.
    always_comb begin
        state_nxt = state;
        pc_nxt    = ProgCtr;
        valid_nxt = InstValid;
        done_nxt  = Done;
        taken_nxt = BranchTaken;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = '0;
                    valid_nxt = 1'b1;
                    done_nxt  = 1'b0;
                    taken_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    if (Halt) begin
                        state_nxt = ST_DONE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                        taken_nxt = 1'b0;
                    end else if (BranchEn && TakeBranch) begin
                        pc_nxt    = branch_target;
                        taken_nxt = 1'b1;
                    end else begin
                        pc_nxt    = ProgCtr + PC_W'(1);
                        taken_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pc_nxt    = '0;
                valid_nxt = 1'b0;
                done_nxt  = 1'b0;
                taken_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic against a behavioural model.
module tb_pc_fetch_unit;

    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int PC_MOD    = 1 << PC_W;

    logic             CLK = 1'b0;
    logic             Reset, Start, Stall, BranchEn, TakeBranch, Halt, LutWrEn;
    logic [IDX_W-1:0] LutIdx;
    logic [PC_W-1:0]  LutWrData;
    logic [PC_W-1:0]  ProgCtr;
    logic             InstValid, Done, BranchTaken;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: running flag, pc as an integer, LUT as plain ints.
    bit m_run, m_valid, m_done, m_bt;
    int m_pc;
    int m_lut [LUT_DEPTH];

    always #5 CLK = ~CLK;

    pc_fetch_unit #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
        .TakeBranch(TakeBranch), .Halt(Halt), .LutIdx(LutIdx), .LutWrEn(LutWrEn),
        .LutWrData(LutWrData), .ProgCtr(ProgCtr), .InstValid(InstValid), .Done(Done),
        .BranchTaken(BranchTaken)
    );

    function automatic logic [PC_W+2:0] model_out();
        return {PC_W'(m_pc), m_valid, m_done, m_bt};
    endfunction

    function automatic int target_of(input int pc, input int idx);
`ifdef RELATIVE_BRANCH_EN
        return (pc + m_lut[idx]) % PC_MOD;
`else
        return m_lut[idx];
`endif
    endfunction

    // Apply one cycle of inputs, advance the model, then wait past the edge.
    task automatic step(input bit rst, input bit start, input bit stall, input bit ben,
                        input bit tkb, input bit halt, input int idx, input bit wen, input int wdata);
        Reset = rst; Start = start; Stall = stall; BranchEn = ben; TakeBranch = tkb;
        Halt = halt; LutIdx = IDX_W'(idx); LutWrEn = wen; LutWrData = PC_W'(wdata);
        if (rst) begin
            m_run = 0; m_valid = 0; m_done = 0; m_bt = 0; m_pc = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else if (!m_run) begin
            if (wen) m_lut[idx] = wdata % PC_MOD;
            if (start) begin
                m_run = 1; m_pc = 0; m_valid = 1; m_done = 0; m_bt = 0;
            end
        end else if (!stall) begin
            if (halt) begin
                m_run = 0; m_valid = 0; m_done = 1; m_bt = 0;
            end else if (ben && tkb) begin
                m_pc = target_of(m_pc, idx); m_bt = 1;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD; m_bt = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic adv(); step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 1, 1, 2, 1, 99);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({ProgCtr, InstValid, Done, BranchTaken} !== '0) begin
            n_fail++;
            $display("FAIL reset: pc=%h v=%b d=%b bt=%b, want all 0", ProgCtr, InstValid, Done, BranchTaken);
        end
        adv();
        n_checks++;
        if ({ProgCtr, InstValid, Done, BranchTaken} !== model_out()) begin
            n_fail++;
            $display("FAIL idle_hold: pc=%h v=%b d=%b bt=%b, want %b", ProgCtr, InstValid, Done, BranchTaken, model_out());
        end
    endtask

    task automatic test_sequential();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 5; i++) begin
            n_checks++;
            if (ProgCtr !== PC_W'(i) || InstValid !== 1'b1 || Done !== 1'b0) begin
                n_fail++;
                $display("FAIL seq[%0d]: pc=%h v=%b d=%b, want pc=%h v=1 d=0", i, ProgCtr, InstValid, Done, i);
            end
            // Start while running must be ignored.
            if (i < 5) step(0, (i == 3), 0, 0, (i == 1), 0, 0, 0, 0);
        end
    endtask

    task automatic test_branch();
        logic [PC_W-1:0] want;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 3, 1, 'h120);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) adv();
        step(0, 0, 0, 1, 1, 0, 3, 0, 0);
`ifdef RELATIVE_BRANCH_EN
        want = 10'h127;
`else
        want = 10'h120;
`endif
        n_checks++;
        if (ProgCtr !== want || BranchTaken !== 1'b1 || {ProgCtr, InstValid, Done, BranchTaken} !== model_out()) begin
            n_fail++;
            $display("FAIL branch: pc=%h bt=%b, want pc=%h bt=1", ProgCtr, BranchTaken, want);
        end
        step(0, 0, 0, 0, 1, 0, 3, 0, 0);
        n_checks++;
        if (ProgCtr !== want + 10'd1 || BranchTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_ignored: pc=%h bt=%b, want pc=%h bt=0", ProgCtr, BranchTaken, want + 10'd1);
        end
    endtask

    task automatic test_stall();
        logic [PC_W-1:0] want;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 3, 1, 'h120);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) adv();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 1, 1, 0, 3, 0, 0);
            n_checks++;
            if (ProgCtr !== 10'd9 || InstValid !== 1'b1 || BranchTaken !== 1'b0) begin
                n_fail++;
                $display("FAIL stall[%0d]: pc=%h v=%b bt=%b, want pc=009 v=1 bt=0", i, ProgCtr, InstValid, BranchTaken);
            end
        end
        step(0, 0, 0, 1, 1, 0, 3, 0, 0);
`ifdef RELATIVE_BRANCH_EN
        want = 10'h129;
`else
        want = 10'h120;
`endif
        n_checks++;
        if (ProgCtr !== want || BranchTaken !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: pc=%h bt=%b, want pc=%h bt=1", ProgCtr, BranchTaken, want);
        end
        // Stall must also hold a set BranchTaken.
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ProgCtr !== want || BranchTaken !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold_bt: pc=%h bt=%b, want pc=%h bt=1", ProgCtr, BranchTaken, want);
        end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] want;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 'h3FF);
        step(0, 0, 0, 0, 0, 0, 2, 1, 'h3FE);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 1, 0, 0);
        n_checks++;
        if (ProgCtr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL wrap_setup: pc=%h, want 3ff", ProgCtr);
        end
        adv();
        n_checks++;
        if (ProgCtr !== 10'h000 || InstValid !== 1'b1 || BranchTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: pc=%h v=%b bt=%b, want pc=000 v=1 bt=0", ProgCtr, InstValid, BranchTaken);
        end
        adv(); adv();
        step(0, 0, 0, 1, 1, 0, 2, 0, 0);
`ifdef RELATIVE_BRANCH_EN
        want = 10'h000;
`else
        want = 10'h3FE;
`endif
        n_checks++;
        if (ProgCtr !== want || BranchTaken !== 1'b1) begin
            n_fail++;
            $display("FAIL offset_wrap: pc=%h bt=%b, want pc=%h bt=1", ProgCtr, BranchTaken, want);
        end
    endtask

    task automatic test_halt_lut_guard();
        logic [PC_W-1:0] want;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 5, 1, 'h0AA);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 5, 1, 'h155);
        repeat (3) adv();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ProgCtr !== 10'd4 || InstValid !== 1'b0 || Done !== 1'b1) begin
                n_fail++;
                $display("FAIL halt[%0d]: pc=%h v=%b d=%b, want pc=004 v=0 d=1", i, ProgCtr, InstValid, Done);
            end
            if (i == 1) step(0, 0, 0, 0, 0, 0, 6, 1, 'h2C3);
            else adv();
        end
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ProgCtr !== 10'd0 || InstValid !== 1'b1 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: pc=%h v=%b d=%b, want pc=000 v=1 d=0", ProgCtr, InstValid, Done);
        end
        step(0, 0, 0, 1, 1, 0, 5, 0, 0);
        n_checks++;
        if (ProgCtr !== 10'h0AA) begin
            n_fail++;
            $display("FAIL run_write_dropped: pc=%h, want 0aa", ProgCtr);
        end
        step(0, 0, 0, 1, 1, 0, 6, 0, 0);
`ifdef RELATIVE_BRANCH_EN
        want = 10'(10'h0AA + 10'h2C3);
`else
        want = 10'h2C3;
`endif
        n_checks++;
        if (ProgCtr !== want) begin
            n_fail++;
            $display("FAIL done_write: pc=%h, want %h", ProgCtr, want);
        end
    endtask

    task automatic test_reset_mid_stall();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 3, 1, 'h120);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) adv();
        step(1, 0, 1, 1, 1, 0, 3, 0, 0);
        n_checks++;
        if ({ProgCtr, InstValid, Done, BranchTaken} !== '0) begin
            n_fail++;
            $display("FAIL reset_stall: pc=%h v=%b d=%b bt=%b, want all 0", ProgCtr, InstValid, Done, BranchTaken);
        end
        repeat (3) step(0, 0, 0, 1, 1, 0, 3, 0, 0);
        n_checks++;
        if ({ProgCtr, InstValid, Done, BranchTaken} !== '0) begin
            n_fail++;
            $display("FAIL abort_needs_start: pc=%h v=%b d=%b bt=%b, want all 0", ProgCtr, InstValid, Done, BranchTaken);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        adv(); adv();
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 1, 0, k * 4 + 3, 0, 0);
            n_checks++;
`ifdef RELATIVE_BRANCH_EN
            if (ProgCtr !== 10'd2 || BranchTaken !== 1'b1) begin
                n_fail++;
                $display("FAIL lut_cleared[%0d]: pc=%h bt=%b, want pc=002 bt=1", k, ProgCtr, BranchTaken);
            end
`else
            if (ProgCtr !== 10'd0 || BranchTaken !== 1'b1) begin
                n_fail++;
                $display("FAIL lut_cleared[%0d]: pc=%h bt=%b, want pc=000 bt=1", k, ProgCtr, BranchTaken);
            end
            adv(); adv();
`endif
        end
    endtask

    task automatic test_random();
        bit rst, start, stall, ben, tkb, halt, wen;
        int idx, wdata;
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 7) == 0);
            stall = m_run && ($urandom_range(0, 4) == 0);
            halt  = ($urandom_range(0, 24) == 0);
            ben   = $urandom_range(0, 1) == 1;
            tkb   = $urandom_range(0, 1) == 1;
            wen   = ($urandom_range(0, 3) == 0);
            idx   = $urandom_range(0, LUT_DEPTH - 1);
            wdata = $urandom_range(0, PC_MOD - 1);
            step(rst, start, stall, ben, tkb, halt, idx, wen, wdata);
            n_checks++;
            if ({ProgCtr, InstValid, Done, BranchTaken} !== model_out()) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h v=%b d=%b bt=%b, want pc=%h v=%b d=%b bt=%b",
                         i, ProgCtr, InstValid, Done, BranchTaken, PC_W'(m_pc), m_valid, m_done, m_bt);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0; TakeBranch = 1'b0;
        Halt = 1'b0; LutIdx = '0; LutWrEn = 1'b0; LutWrData = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wrap();
        test_halt_lut_guard();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
